// File: rtl/spi_mem_responder.sv
// spi_mem_responder: serial frame slave holding a DEPTH x DATA_W register file, answering write and read frames
module spi_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done,
  output logic frame_err
);
  localparam int FL = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FL + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, LEAD, RX, COMMIT, RD_FETCH, TX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [FL-1:0] frame, frame_nx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] shreg, rd_word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic armed, oor, oor_nx;
  // the range check on frame_nx lets frame_err line up with ready/op_done
  always_comb begin
    frame_nx = frame | (FL'(mosi) << cnt);
    addr = frame[ADDR_W:1];
    oor_nx = 32'(frame_nx[ADDR_W:1]) >= DEPTH;
    oor = 32'(addr) >= DEPTH;
    rd_word = oor ? '0 : mem[addr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      frame <= '0;
      shreg <= '0;
      armed <= 1'b0;
      miso <= 1'b0;
      ready <= 1'b0;
      op_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready <= 1'b0;
      op_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs) armed <= 1'b1;
          else if (armed) begin
            state <= LEAD;
            armed <= 1'b0;
            cnt <= '0;
            frame <= '0;
          end
        end
        LEAD: state <= RX;
        RX: begin
          if (cs) begin
            frame_err <= 1'b1;
            armed <= 1'b1;
            state <= IDLE;
          end else begin
            frame <= frame_nx;
            cnt <= cnt + 1'b1;
            if (!frame[0] && cnt == CW'(ADDR_W)) begin
              state <= RD_FETCH;
              ready <= 1'b1;
              frame_err <= oor_nx;
            end else if (frame[0] && cnt == CW'(FL - 1)) begin
              state <= COMMIT;
              op_done <= 1'b1;
              frame_err <= oor_nx;
            end
          end
        end
        COMMIT: begin
          if (!oor) mem[addr[AW-1:0]] <= frame[FL-1:1+ADDR_W];
          state <= IDLE;
        end
        RD_FETCH: begin
          miso <= rd_word[0];
          shreg <= rd_word >> 1;
          cnt <= CW'(1);
          state <= TX;
        end
        TX: begin
          if (cnt == CW'(DATA_W)) begin
            miso <= 1'b0;
            state <= IDLE;
          end else begin
            miso <= shreg[0];
            shreg <= shreg >> 1;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: scoreboard bench driving write/read/abort frames against spi_mem_responder
module tb_spi_mem_responder;
  logic clk = 0, rst = 1, cs = 1, mosi = 0;
  logic miso, ready, op_done, frame_err;
  int checks = 0, errors = 0;
  logic [7:0] model [32];
  logic [7:0] exp_q [$];

  spi_mem_responder dut (.clk(clk), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso),
    .ready(ready), .op_done(op_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cs = 0;
    mosi = 1;
    tick();
    tick();
  endtask

  task automatic shift(input logic [16:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = f[i];
      tick();
    end
  endtask

  task automatic end_frame();
    cs = 1;
    mosi = 0;
    tick();
    tick();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic exp_err;
    exp_err = a >= 8'd32;
    start_frame();
    shift({d, a, 1'b1}, 17);
    checks++;
    if (op_done !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse a=%0d: op_done=%b ready=%b, required op_done=1 ready=0", a, op_done, ready);
    end
    checks++;
    if (frame_err !== exp_err) begin
      errors++;
      $display("FAIL write_err a=%0d: frame_err=%b, required %b", a, frame_err, exp_err);
    end
    tick();
    checks++;
    if (op_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse_width a=%0d: op_done=%b frame_err=%b, required 0 0", a, op_done, frame_err);
    end
    if (!exp_err) model[a[4:0]] = d;
  endtask

  task automatic do_read(input logic [7:0] a);
    logic [7:0] exp;
    logic exp_err;
    exp_err = a >= 8'd32;
    exp_q.push_back(exp_err ? 8'h00 : model[a[4:0]]);
    start_frame();
    shift({8'h00, a, 1'b0}, 9);
    checks++;
    if (ready !== 1'b1 || op_done !== 1'b0 || frame_err !== exp_err) begin
      errors++;
      $display("FAIL read_pulse a=%0d: ready=%b op_done=%b frame_err=%b, required 1 0 %b", a, ready, op_done, frame_err, exp_err);
    end
    exp = exp_q.pop_front();
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (miso !== exp[k] || ready !== 1'b0) begin
        errors++;
        $display("FAIL read_bit a=%0d k=%0d: miso=%b ready=%b, required miso=%b ready=0", a, k, miso, ready, exp[k]);
      end
    end
    tick();
    checks++;
    if (miso !== 1'b0) begin
      errors++;
      $display("FAIL read_tail a=%0d: miso=%b, required 0", a, miso);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({miso, ready, op_done, frame_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset: outputs=%b, required 0000", {miso, ready, op_done, frame_err});
    end
    rst = 0;
    tick();
    tick();
  endtask

  task automatic test_write_read();
    do_write(8'd5, 8'hA5);
    end_frame();
    do_read(8'd5);
    end_frame();
    do_write(8'd31, 8'h3C);
    end_frame();
    do_read(8'd31);
    end_frame();
  endtask

  task automatic test_out_of_range();
    do_write(8'd8, 8'h42);
    end_frame();
    do_write(8'd40, 8'hFF);
    end_frame();
    do_read(8'd8);
    end_frame();
    do_read(8'd40);
    end_frame();
  endtask

  task automatic test_abort();
    do_write(8'd7, 8'h11);
    end_frame();
    start_frame();
    shift({8'h99, 8'd7, 1'b1}, 6);
    cs = 1;
    tick();
    checks++;
    if (frame_err !== 1'b1 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL abort: frame_err=%b op_done=%b, required 1 0", frame_err, op_done);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (op_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done cyc=%0d: op_done=%b, required 0", i, op_done);
      end
    end
    do_read(8'd7);
    end_frame();
  endtask

  task automatic test_back_to_back();
    do_write(8'd12, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      mosi = i[0];
      tick();
      checks++;
      if ({ready, op_done, frame_err} !== 3'b0) begin
        errors++;
        $display("FAIL extra_bits cyc=%0d: ready/op_done/frame_err=%b, required 000", i, {ready, op_done, frame_err});
      end
    end
    end_frame();
    do_read(8'd12);
    end_frame();
    do_write(8'd13, 8'hC3);
    end_frame();
    do_read(8'd13);
    end_frame();
  endtask

  task automatic test_reset_mid_tx();
    exp_q.push_back(model[5]);
    start_frame();
    shift({8'h00, 8'd5, 1'b0}, 9);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (miso !== model[5][3]) begin
      errors++;
      $display("FAIL tx_bit3: miso=%b, required %b", miso, model[5][3]);
    end
    void'(exp_q.pop_front());
    rst = 1;
    tick();
    checks++;
    if ({miso, ready, op_done, frame_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_tx: outputs=%b, required 0000", {miso, ready, op_done, frame_err});
    end
    rst = 0;
    end_frame();
    do_write(8'd20, 8'h96);
    end_frame();
    do_read(8'd20);
    end_frame();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
